// File: rtl/vga_timing_pkg.sv
// Default 640x480 @ 60 Hz VGA timing constants shared by the display path.
package vga_timing_pkg;

    localparam int unsigned CLK_DIV   = 4;
    localparam int unsigned COORD_W   = 10;

    localparam int unsigned H_DISPLAY = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_DISPLAY = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned HSYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HSYNC_END   = HSYNC_START + H_SYNC - 1;
    localparam int unsigned VSYNC_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VSYNC_END   = VSYNC_START + V_SYNC - 1;

endpackage

// File: rtl/vga_sync_if.sv
// Timing bundle from the sync generator to the pixel generator and connector.
interface vga_sync_if;
    import vga_timing_pkg::*;

    logic               hsync;
    logic               vsync;
    logic               vd_on;
    logic               p_tick;
    logic               f_tick;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;

    modport master (
        output hsync, vsync, vd_on, p_tick, f_tick, pixel_x, pixel_y
    );

    modport slave (
        input hsync, vsync, vd_on, p_tick, f_tick, pixel_x, pixel_y
    );

endinterface

// File: rtl/mod_m_counter.sv
// Free-running modulo-M counter with a terminal-count flag.
module mod_m_counter #(
    parameter int unsigned M = 4,
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst,
    output logic [W-1:0] count,
    output logic         max_tick
);

    // Count 0..M-1 and wrap; synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (count == W'(M - 1)) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    assign max_tick = (count == W'(M - 1));

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: pixel-rate divider plus cascaded h/v counters.
module vga_sync #(
    parameter int unsigned CLK_DIV   = vga_timing_pkg::CLK_DIV,
    parameter int unsigned H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int unsigned H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK    = vga_timing_pkg::H_BACK,
    parameter int unsigned V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int unsigned V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic       clk,
    input  logic       rst,
    vga_sync_if.master vga
);

    localparam int unsigned CW          = vga_timing_pkg::COORD_W;
    localparam int unsigned DIV_W       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL     = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL     = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HSYNC_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HSYNC_END   = HSYNC_START + H_SYNC - 1;
    localparam int unsigned VSYNC_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VSYNC_END   = VSYNC_START + V_SYNC - 1;

    logic [DIV_W-1:0] div_cnt;
    logic             p_tick;
    logic [CW-1:0]    pixel_x, pixel_y;
    logic [CW-1:0]    x_next, y_next;
    logic             hsync, vsync;
    logic             hsync_next, vsync_next;

    mod_m_counter #(
        .M (CLK_DIV),
        .W (DIV_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .count    (div_cnt),
        .max_tick (p_tick)
    );

    // Next coordinates: advance x on each pixel tick, carry into y on line wrap.
    always_comb begin
        x_next = pixel_x;
        y_next = pixel_y;
        if (p_tick) begin
            if (pixel_x == CW'(H_TOTAL - 1)) begin
                x_next = '0;
                if (pixel_y == CW'(V_TOTAL - 1)) begin
                    y_next = '0;
                end else begin
                    y_next = pixel_y + CW'(1);
                end
            end else begin
                x_next = pixel_x + CW'(1);
            end
        end
    end

    // Sync levels decoded from the next coordinates so they move with the counters.
    always_comb begin
        hsync_next = !((x_next >= CW'(HSYNC_START)) && (x_next <= CW'(HSYNC_END)));
        vsync_next = !((y_next >= CW'(VSYNC_START)) && (y_next <= CW'(VSYNC_END)));
    end

    // Coordinate and sync registers; reset overrides counting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pixel_x <= '0;
            pixel_y <= '0;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
        end else begin
            pixel_x <= x_next;
            pixel_y <= y_next;
            hsync   <= hsync_next;
            vsync   <= vsync_next;
        end
    end

    // Counters and divider phase must stay inside their modulus.
    a_range: assert property (@(posedge clk) disable iff (!rst)
        (32'(div_cnt) < CLK_DIV) && (32'(pixel_x) < H_TOTAL) && (32'(pixel_y) < V_TOTAL));

    assign vga.pixel_x = pixel_x;
    assign vga.pixel_y = pixel_y;
    assign vga.hsync   = hsync;
    assign vga.vsync   = vsync;
    assign vga.p_tick  = p_tick;
    assign vga.vd_on   = (pixel_x < CW'(H_DISPLAY)) && (pixel_y < CW'(V_DISPLAY));
    assign vga.f_tick  = p_tick && (pixel_x == CW'(H_TOTAL - 1)) && (pixel_y == CW'(V_TOTAL - 1));

endmodule

// File: tb/tb_vga_sync.sv
// Random-reset bench comparing three vga_sync configurations to an elapsed-time model.
module tb_vga_sync;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    vga_sync_if if_a ();
    vga_sync_if if_b ();
    vga_sync_if if_c ();

    // Default timing.
    vga_sync u_a (.clk(clk), .rst(rst), .vga(if_a));

    // Faster pixel rate, default windows.
    vga_sync #(.CLK_DIV(2)) u_b (.clk(clk), .rst(rst), .vga(if_b));

    // Tiny raster so whole frames fit in the run.
    vga_sync #(
        .CLK_DIV(2),
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_c (.clk(clk), .rst(rst), .vga(if_c));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after t clocks since reset: pixel index = t / div, raster position from that.
    task automatic check_inst(
        input string nm, input longint unsigned t, input int unsigned div,
        input int unsigned hd, input int unsigned hf, input int unsigned hs, input int unsigned hb,
        input int unsigned vd, input int unsigned vf, input int unsigned vs, input int unsigned vb,
        input logic hsync, input logic vsync, input logic vd_on,
        input logic p_tick, input logic f_tick,
        input logic [9:0] px, input logic [9:0] py);
        int unsigned     ht, vt, ex, ey;
        longint unsigned n;
        logic            ept;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        n   = t / longint'(div);
        ex  = 32'(n % longint'(ht));
        ey  = 32'((n / longint'(ht)) % longint'(vt));
        ept = ((t % longint'(div)) == longint'(div - 1));
        check({nm, ".pixel_x"}, 32'(px), ex);
        check({nm, ".pixel_y"}, 32'(py), ey);
        check({nm, ".p_tick"}, 32'(p_tick), 32'(ept));
        check({nm, ".hsync"}, 32'(hsync), 32'(!(ex >= hd + hf && ex < hd + hf + hs)));
        check({nm, ".vsync"}, 32'(vsync), 32'(!(ey >= vd + vf && ey < vd + vf + vs)));
        check({nm, ".vd_on"}, 32'(vd_on), 32'(ex < hd && ey < vd));
        check({nm, ".f_tick"}, 32'(f_tick), 32'(ept && ex == ht - 1 && ey == vt - 1));
    endtask

    initial begin
        longint unsigned t        = 0;
        longint          f_last   = -1;
        bit              valid    = 1'b0;
        int              rst_left = 5;
        int              frames   = 0;

        for (int cyc = 0; cyc < 60000; cyc++) begin
            @(negedge clk);
            if (valid) begin
                check_inst("a", t, 4, 640, 16, 96, 48, 480, 10, 2, 33,
                           if_a.hsync, if_a.vsync, if_a.vd_on, if_a.p_tick, if_a.f_tick,
                           if_a.pixel_x, if_a.pixel_y);
                check_inst("b", t, 2, 640, 16, 96, 48, 480, 10, 2, 33,
                           if_b.hsync, if_b.vsync, if_b.vd_on, if_b.p_tick, if_b.f_tick,
                           if_b.pixel_x, if_b.pixel_y);
                check_inst("c", t, 2, 8, 2, 3, 2, 6, 2, 2, 3,
                           if_c.hsync, if_c.vsync, if_c.vd_on, if_c.p_tick, if_c.f_tick,
                           if_c.pixel_x, if_c.pixel_y);
                // Frame period of the tiny raster: 15 * 13 pixels * 2 clocks.
                if (if_c.f_tick === 1'b1) begin
                    if (f_last >= 0) begin
                        check("c.frame_len", 32'(longint'(t) - f_last), 32'd390);
                        frames++;
                    end
                    f_last = longint'(t);
                end
            end

            if (rst_left == 0 && cyc > 20 && $urandom_range(0, 14999) == 0) begin
                rst_left = int'($urandom_range(1, 5));
            end
            if (rst_left > 0) begin
                rst = 1'b0;
                rst_left--;
            end else begin
                rst = 1'b1;
            end

            @(posedge clk);
            if (!rst) begin
                t      = 0;
                valid  = 1'b1;
                f_last = -1;
            end else begin
                t++;
            end
        end

        check("c.frames_seen_min", 32'(frames > 10), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
